// File: rtl/game_pkg.sv
// Shared types and constants for the ping-pong game controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: controller state encoding, winner output codes, default goal
// targets and a helper that sizes the pause counter.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SERVE,
    ST_RALLY,
    ST_PAUSE,
    ST_OVER
  } state_e;

  localparam logic [1:0] WIN_IDLE = 2'b00;
  localparam logic [1:0] WIN_PLAY = 2'b01;
  localparam logic [1:0] WIN_P1   = 2'b10;
  localparam logic [1:0] WIN_P2   = 2'b11;

  localparam int unsigned DEF_SHORT_TARGET = 5;
  localparam int unsigned DEF_LONG_TARGET  = 9;

  // The counter must hold PAUSE_CYCLES-1. A 1-cycle pause still needs a
  // 1-bit counter, so the width never drops to zero.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/pause_timer.sv
// Loadable down-counter that times the pause between points.
// Latency: load takes effect on the next edge; done is a decode of the count.
// Backpressure: none; en only advances the count, which saturates at zero.
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-low; clears the count
//   load   in   load PAUSE_CYCLES-1 (wins over en)
//   en     in   decrement by one while non-zero
//   done   out  count is zero
module pause_timer
  import game_pkg::*;
#(
  parameter int unsigned PAUSE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int unsigned CNT_W = cnt_width(PAUSE_CYCLES);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(PAUSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = LOAD_VAL;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/match_sequencer.sv
// Game controller: starts a match, serves, counts goals, pauses between points, declares the winner.
// Latency: every output is registered; a goal in RALLY shows on the outputs one cycle later.
// Backpressure: none; start/goal pulses arriving in states that do not use them are dropped.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-low; back to IDLE with cleared outputs
//   start      in   pulse; begins/restarts a match from IDLE or OVER
//   long_mode  in   target select, sampled only on an accepted start
//   goal_p1/2  in   pulse; player 1/2 scored (only counted in RALLY)
//   ball_load  out  pulse during SERVE: recentre ball, load serve_dir
//   ball_run   out  level, high in RALLY
//   serve_dir  out  0 = toward player 1, 1 = toward player 2
//   p1/p2_score out goal counts
//   winner     out  WIN_IDLE / WIN_PLAY / WIN_P1 / WIN_P2
module match_sequencer
  import game_pkg::*;
#(
  parameter int unsigned PAUSE_CYCLES = 50_000_000,
  parameter int unsigned SHORT_TARGET = DEF_SHORT_TARGET,
  parameter int unsigned LONG_TARGET  = DEF_LONG_TARGET
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       long_mode,
  input  logic       goal_p1,
  input  logic       goal_p2,
  output logic       ball_load,
  output logic       ball_run,
  output logic       serve_dir,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] winner
);

  localparam logic [3:0] SHORT_T = 4'(SHORT_TARGET);
  localparam logic [3:0] LONG_T  = 4'(LONG_TARGET);

  state_e     state_q;
  logic [3:0] p1_score_q, p2_score_q, target_q;
  logic [1:0] winner_q;
  logic       serve_dir_q, ball_load_q, ball_run_q;

  logic [3:0] p1_score_d, p2_score_d;
  logic       p1_only, p2_only, p1_hit, p2_hit;
  logic       in_rally, point_end, match_won;
  logic       timer_load, timer_en, timer_done;

  assign p1_score_d = p1_score_q + 4'd1;
  assign p2_score_d = p2_score_q + 4'd1;
  assign p1_only    = goal_p1 & ~goal_p2;
  assign p2_only    = goal_p2 & ~goal_p1;
  assign p1_hit     = (p1_score_d == target_q);
  assign p2_hit     = (p2_score_d == target_q);

  assign in_rally   = (state_q == ST_RALLY);
  // Any goal pulse ends the point; simultaneous goals end it without a score.
  assign point_end  = in_rally & (goal_p1 | goal_p2);
  assign match_won  = in_rally & ((p1_only & p1_hit) | (p2_only & p2_hit));
  assign timer_load = point_end & ~match_won;
  assign timer_en   = (state_q == ST_PAUSE);

  pause_timer #(
    .PAUSE_CYCLES(PAUSE_CYCLES)
  ) u_pause_timer (
    .clk  (clk),
    .reset(reset),
    .load (timer_load),
    .en   (timer_en),
    .done (timer_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      p1_score_q  <= '0;
      p2_score_q  <= '0;
      target_q    <= SHORT_T;
      winner_q    <= WIN_IDLE;
      serve_dir_q <= 1'b0;
      ball_load_q <= 1'b0;
      ball_run_q  <= 1'b0;
    end else begin
      ball_load_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            p1_score_q  <= '0;
            p2_score_q  <= '0;
            target_q    <= long_mode ? LONG_T : SHORT_T;
            serve_dir_q <= 1'b0;
            winner_q    <= WIN_PLAY;
            ball_load_q <= 1'b1;
            state_q     <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          ball_run_q <= 1'b1;
          state_q    <= ST_RALLY;
        end
        ST_RALLY: begin
          if (point_end) begin
            ball_run_q <= 1'b0;
            state_q    <= ST_PAUSE;
            // The loser of the point receives the next serve.
            if (p1_only) begin
              p1_score_q  <= p1_score_d;
              serve_dir_q <= 1'b1;
              if (p1_hit) begin
                winner_q <= WIN_P1;
                state_q  <= ST_OVER;
              end
            end else if (p2_only) begin
              p2_score_q  <= p2_score_d;
              serve_dir_q <= 1'b0;
              if (p2_hit) begin
                winner_q <= WIN_P2;
                state_q  <= ST_OVER;
              end
            end
          end
        end
        ST_PAUSE: begin
          if (timer_done) begin
            ball_load_q <= 1'b1;
            state_q     <= ST_SERVE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ball_load = ball_load_q;
  assign ball_run  = ball_run_q;
  assign serve_dir = serve_dir_q;
  assign p1_score  = p1_score_q;
  assign p2_score  = p2_score_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Bench for match_sequencer with a 4-cycle pause. Stimulus tasks push the
// expected output snapshot and the cycle it must appear in; a monitor pops
// one entry for every change it sees on the DUT outputs.
module tb_match_sequencer;

  typedef struct packed {
    logic       ld;
    logic       run;
    logic       dir;
    logic [3:0] p1;
    logic [3:0] p2;
    logic [1:0] win;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset, start, long_mode, goal_p1, goal_p2;
  logic       ball_load, ball_run, serve_dir;
  logic [3:0] p1_score, p2_score;
  logic [1:0] winner;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   mon_en = 0;
  obs_t exp_q[$];
  int   exp_cyc_q[$];
  obs_t m;
  int   tgt;

  match_sequencer #(
    .PAUSE_CYCLES(4),
    .SHORT_TARGET(5),
    .LONG_TARGET (9)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .long_mode(long_mode),
    .goal_p1  (goal_p1),
    .goal_p2  (goal_p2),
    .ball_load(ball_load),
    .ball_run (ball_run),
    .serve_dir(serve_dir),
    .p1_score (p1_score),
    .p2_score (p2_score),
    .winner   (winner)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: any change of the output tuple is one scoreboard event.
  obs_t cur, prev, e;
  int   ec;
  int   ev = 0;
  bit   first = 1;
  always @(negedge clk) begin
    if (mon_en) begin
      cur = '{ld: ball_load, run: ball_run, dir: serve_dir,
              p1: p1_score, p2: p2_score, win: winner};
      if (first || (cur !== prev)) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change cyc=%0d got ld=%0d run=%0d dir=%0d p1=%0d p2=%0d win=%b, required no change",
                   cyc, cur.ld, cur.run, cur.dir, cur.p1, cur.p2, cur.win);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          if ((cur !== e) || ((ec >= 0) && (ec != cyc))) begin
            n_fail++;
            $display("FAIL ev%0d cyc=%0d got ld=%0d run=%0d dir=%0d p1=%0d p2=%0d win=%b, required cyc=%0d ld=%0d run=%0d dir=%0d p1=%0d p2=%0d win=%b",
                     ev, cyc, cur.ld, cur.run, cur.dir, cur.p1, cur.p2, cur.win,
                     ec, e.ld, e.run, e.dir, e.p1, e.p2, e.win);
          end
        end
        ev++;
        first = 0;
      end
      prev = cur;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input obs_t o, input int c);
    exp_q.push_back(o);
    exp_cyc_q.push_back(c);
  endtask

  // Start a match; returns in the first RALLY cycle.
  task automatic do_start(input logic lm);
    int c;
    c = cyc;
    start = 1'b1;
    long_mode = lm;
    step();
    start = 1'b0;
    long_mode = ~lm;       // later changes must not alter the target
    tgt = lm ? 9 : 5;
    m = '{ld: 1'b1, run: 1'b0, dir: 1'b0, p1: 4'd0, p2: 4'd0, win: 2'b01};
    push(m, c + 1);
    m.ld = 1'b0;
    m.run = 1'b1;
    push(m, c + 2);
    step();
  endtask

  // One point from RALLY. mode 0: plain pause; 1: goal_p2 and start during
  // the pause; 2: reset during the pause. Returns in the next RALLY cycle.
  task automatic goal(input logic g1, input logic g2, input int mode);
    int c;
    bit won;
    c = cyc;
    won = 0;
    goal_p1 = g1;
    goal_p2 = g2;
    step();
    goal_p1 = 1'b0;
    goal_p2 = 1'b0;
    m.run = 1'b0;
    if (g1 && !g2) begin
      m.p1 = m.p1 + 4'd1;
      m.dir = 1'b1;
      if (int'(m.p1) == tgt) begin m.win = 2'b10; won = 1; end
    end else if (g2 && !g1) begin
      m.p2 = m.p2 + 4'd1;
      m.dir = 1'b0;
      if (int'(m.p2) == tgt) begin m.win = 2'b11; won = 1; end
    end
    push(m, c + 1);
    if (won) return;
    if (mode == 2) begin
      step();
      reset = 1'b0;
      step();
      reset = 1'b1;
      m = '0;
      push(m, c + 3);
      return;
    end
    if (mode == 1) begin
      step();
      goal_p2 = 1'b1;
      start = 1'b1;
      step();
      goal_p2 = 1'b0;
      start = 1'b0;
    end
    m.ld = 1'b1;
    push(m, c + 5);
    m.ld = 1'b0;
    m.run = 1'b1;
    push(m, c + 6);
    while (cyc < c + 6) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    long_mode = 1'b0;
    goal_p1 = 1'b0;
    goal_p2 = 1'b0;
    m = '0;
    tgt = 5;
    repeat (3) step();
    reset = 1'b1;
    push(m, -1);           // reset state, checked on the first sample
    mon_en = 1;
    step();

    // Short match, then reset in the middle of a pause with p1 at 3.
    do_start(1'b0);
    goal(1'b1, 1'b0, 0);
    goal(1'b1, 1'b0, 0);
    start = 1'b1;          // ignored in RALLY
    step();
    start = 1'b0;
    goal(1'b1, 1'b0, 2);
    repeat (3) step();     // IDLE: nothing should change

    // Short match: replay on simultaneous goals, noise during pause, p1 wins.
    do_start(1'b0);
    goal(1'b1, 1'b0, 0);   // serve_dir -> 1
    goal(1'b1, 1'b1, 0);   // replay, serve_dir stays 1
    goal(1'b0, 1'b1, 1);   // p2 = 1, pause ignores goal_p2/start
    for (int i = 0; i < 4; i++) goal(1'b1, 1'b0, 0);
    repeat (2) step();
    goal_p1 = 1'b1;        // ignored in OVER
    step();
    goal_p1 = 1'b0;
    repeat (2) step();

    // Long match from OVER: p1 reaches 5 without winning, p2 wins at 9.
    do_start(1'b1);
    for (int i = 0; i < 5; i++) goal(1'b1, 1'b0, 0);
    for (int i = 0; i < 9; i++) goal(1'b0, 1'b1, 0);
    repeat (10) step();

    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_events got %0d outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
